// File: rtl/conv_pkg.sv
// Shared types, widths and the identity-kernel helper for the 3x3 convolution engine.
package conv_pkg;

  localparam int KERNEL_TAPS   = 9;
  localparam int CENTRE_TAP    = 4;
  localparam int KERNEL_COEF_W = 8;

  // Row-major 3x3 kernel at the default coefficient width, tap 0 = top-left.
  typedef logic signed [KERNEL_COEF_W-1:0] kernel_t [KERNEL_TAPS];

  // Accumulator width: pixel plus coefficient plus headroom for nine signed products.
  function automatic int acc_width(input int word_size, input int coef_width);
    return word_size + coef_width + 5;
  endfunction

  // Identity kernel tap value: unity gain at the centre once the sum is shifted down.
  function automatic int identity_coef(input int tap, input int shift);
    return (tap == CENTRE_TAP) ? (1 << shift) : 0;
  endfunction

endpackage

// File: rtl/conv3x3_stream_line_buffer.sv
// One image row of storage with asynchronous read and read-before-write on the accepted address.
module line_buffer
  import conv_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 540
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_SIZE-1:0]     wr_data,
  output logic [WORD_SIZE-1:0]     rd_data
);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Overwrite the slot after its old contents have been read out this cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with loadable double-banked kernel and valid/ready handshakes.
// Define CONV_RELU_EN to clamp negative results to zero; otherwise the magnitude is taken.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ROW_SIZE     = 540,
  parameter int IMAGE_HEIGHT = 360,
  parameter int COEF_WIDTH   = 8,
  parameter int SHIFT        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [WORD_SIZE-1:0]         in_pixel,
  input  logic                         coef_wr,
  input  logic [3:0]                   coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_SIZE-1:0]         out_pixel,
  output logic                         out_eol,
  output logic                         out_eof
);

  localparam int COL_W  = $clog2(ROW_SIZE);
  localparam int ROW_W  = $clog2(IMAGE_HEIGHT);
  localparam int ACC_W  = acc_width(WORD_SIZE, COEF_WIDTH);
  localparam int PROD_W = WORD_SIZE + 1 + COEF_WIDTH;
  localparam logic [COL_W-1:0]     COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [WORD_SIZE-1:0] PIX_MAX  = '1;

  logic en, accept, complete, frame_start;
  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic signed [COEF_WIDTH-1:0] shadow_k [KERNEL_TAPS];
  logic signed [COEF_WIDTH-1:0] active_k [KERNEL_TAPS];
  logic [WORD_SIZE-1:0] lb0_rd, lb1_rd;
  logic [WORD_SIZE-1:0] win [KERNEL_TAPS];
  logic v1, eol1, eof1;
  logic signed [PROD_W-1:0] prod [KERNEL_TAPS];
  logic v2, eol2, eof2;
  logic [WORD_SIZE-1:0] res3;
  logic v3, eol3, eof3;
  logic signed [ACC_W-1:0] sum, shifted, mag;
  logic [WORD_SIZE-1:0] clipped;

  // The whole pipeline moves together whenever the output register can be refilled.
  assign en          = !out_valid || out_ready;
  assign in_ready    = en;
  assign accept      = in_valid && en;
  assign cur_col     = in_sof ? '0 : col;
  assign cur_row     = in_sof ? '0 : row;
  assign frame_start = accept && (cur_row == '0) && (cur_col == '0);
  assign complete    = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

  // Raster position of the next pixel; start-of-frame restarts it from the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col <= cur_col + COL_W'(1);
        row <= cur_row;
      end
    end
  end

  // Shadow bank takes writes any time; the active bank only changes at a frame's first pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < KERNEL_TAPS; t++) begin
        shadow_k[t] <= COEF_WIDTH'(identity_coef(t, SHIFT));
        active_k[t] <= COEF_WIDTH'(identity_coef(t, SHIFT));
      end
    end else begin
      if (frame_start) active_k <= shadow_k;
      if (coef_wr && (coef_addr < 4'd9)) shadow_k[coef_addr] <= coef_data;
    end
  end

  // Two cascaded rows: row-1 lives in lb0 and drops into lb1 as it ages to row-2.
  line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(ROW_SIZE)) u_lb0 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (cur_col),
    .wr_data (in_pixel),
    .rd_data (lb0_rd)
  );

  line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(ROW_SIZE)) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (cur_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Stage 1: slide the 3x3 window left and tag whether it now covers an interior pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < KERNEL_TAPS; t++) win[t] <= '0;
      v1   <= 1'b0;
      eol1 <= 1'b0;
      eof1 <= 1'b0;
    end else if (en) begin
      v1   <= complete;
      eol1 <= complete && (cur_col == COL_LAST);
      eof1 <= complete && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r*3]   <= win[r*3+1];
          win[r*3+1] <= win[r*3+2];
        end
        win[2] <= lb1_rd;
        win[5] <= lb0_rd;
        win[8] <= in_pixel;
      end
    end
  end

  // Stage 2: nine unsigned-pixel by signed-coefficient products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < KERNEL_TAPS; t++) prod[t] <= '0;
      v2   <= 1'b0;
      eol2 <= 1'b0;
      eof2 <= 1'b0;
    end else if (en) begin
      for (int t = 0; t < KERNEL_TAPS; t++)
        prod[t] <= PROD_W'($signed({1'b0, win[t]})) * PROD_W'(active_k[t]);
      v2   <= v1;
      eol2 <= eol1;
      eof2 <= eof1;
    end
  end

  // Adder tree, floor shift, rectify and clip to the pixel range.
  always_comb begin
    sum = '0;
    for (int t = 0; t < KERNEL_TAPS; t++) sum = sum + ACC_W'(prod[t]);
    shifted = sum >>> SHIFT;
`ifdef CONV_RELU_EN
    mag = shifted[ACC_W-1] ? '0 : shifted;
`else
    mag = shifted[ACC_W-1] ? -shifted : shifted;
`endif
    clipped = (mag > ACC_W'(PIX_MAX)) ? PIX_MAX : mag[WORD_SIZE-1:0];
  end

  // Stage 3: register the post-processed result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res3 <= '0;
      v3   <= 1'b0;
      eol3 <= 1'b0;
      eof3 <= 1'b0;
    end else if (en) begin
      res3 <= clipped;
      v3   <= v2;
      eol3 <= eol2;
      eof3 <= eof2;
    end
  end

  // Output register: holds its contents while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (en) begin
      out_valid <= v3;
      out_pixel <= res3;
      out_eol   <= eol3;
      out_eof   <= eof3;
    end
  end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 2-D convolution engine: the parametrised successor to the fixed single-kernel `convolution` block. It accepts one raster-ordered pixel per accepted beat through a valid/ready handshake. It holds two rows in line buffers and applies a run-time loadable signed 3x3 kernel with shift, rectify and saturate. It emits the (ROW_SIZE-2)x(IMAGE_HEIGHT-2) interior result with end-of-line and end-of-frame flags. It sits between the pixel source (frame reader / previous layer) and the next CNN stage.

## Interface
- WORD_SIZE, 8, pixel width (unsigned)
- ROW_SIZE, 540, pixels per row (>=3)
- IMAGE_HEIGHT, 360, rows per frame (>=3)
- COEF_WIDTH, 8, signed coefficient width
- SHIFT, 4, arithmetic right shift applied to the sum (fixed-point kernel scale)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block can accept
- in_sof  in  1  first pixel of frame; qualified by the accept
- in_pixel  in  WORD_SIZE  input pixel
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  4  kernel index 0..8, row-major, 0 = top-left
- coef_data  in  COEF_WIDTH  signed coefficient
- out_valid  out  1  out_pixel valid
- out_ready  in  1  consumer can accept
- out_pixel  out  WORD_SIZE  result pixel
- out_eol  out  1  last interior column of a row
- out_eof  out  1  last interior pixel of the frame

## Operation
- Accept = in_valid && in_ready. Counters col (0..ROW_SIZE-1) and row (0..IMAGE_HEIGHT-1) advance on accept only. col wraps to 0 and increments row. Row wraps to 0 after the last pixel.
- in_sof on accept forces the pixel to (0,0). Counters continue from there. A partial frame in flight is abandoned and its pending outputs still drain.
- Line buffers: two ROW_SIZE-deep rows. The window shifts left on accept: 3x3 window of rows row-2, row-1, row.
- Window is complete when row>=2 && col>=2. It produces an output centred at (row-1, col-1). No output for border pixels.
- Arithmetic: nine products of zero-extended pixel × signed coefficient. Summed at width WORD_SIZE+COEF_WIDTH+5. Arithmetic shift right by SHIFT (truncate toward -inf), then rectify, then saturate to 2^WORD_SIZE-1.
- Coefficients: writes go to a shadow bank at any time. coef_addr>8 is ignored. The shadow bank is copied to the active bank on an accept with in_sof, or with (row,col)=(0,0). A frame never mixes kernels.
- Reset kernel, both banks: identity, i.e. centre = 1<<SHIFT, others 0.
- out_eol: output for col==ROW_SIZE-1. out_eof: additionally row==IMAGE_HEIGHT-1.

## Timing
- Pipeline: stage 1 window/line-buffer read, stage 2 products, stage 3 adder tree + post-process, then output register.
- All stages advance on en = !out_valid || out_ready. in_ready = en (combinational from out_valid, out_ready).
- Latency: a completing pixel accepted at edge N gives out_valid at edge N+3 (with no stalls).
- Stall: while out_valid && !out_ready, out_pixel, out_eol and out_eof hold stable. in_ready=0. No state changes.
- Throughput: 1 pixel/cycle sustained with out_ready=1.
- Simultaneous coef_wr and bank-swap accept: the write lands in shadow only. It applies from the next frame.
- Reset (any time, mid-frame included): out_valid=0, out_pixel=0, out_eol=0, out_eof=0. in_ready=1 after deassertion. Counters 0, pipeline valids 0, kernel identity. Line-buffer contents are don't-care.

## Configuration
- CONV_RELU_EN defined: negative shifted sums clamp to 0.
- CONV_RELU_EN undefined: absolute value is taken (edge-magnitude mode).
- In both modes, values above 2^WORD_SIZE-1 saturate.

## Structure
- Package conv_pkg holds:
  - kernel_t: 9-entry array of signed COEF_WIDTH.
  - IDENTITY kernel constant function.
  - Accumulator width localparam formula.
- Sub-module line_buffer: single-port ROW_SIZE-deep WORD_SIZE RAM with read-before-write on one address per accept. Instantiated twice.

## Test plan
- Identity kernel, 8x6 frame (ROW_SIZE=8, IMAGE_HEIGHT=6), ramp pixel = 10*row+col. Expect 24 outputs equal to centre inputs 11..46 interior. eol at every 6th output, eof on the last.
- Kernel all 1, SHIFT=0, constant input 200. Expect 1800 saturated to 255. Kernel centre -1 under relu: 0. Under abs: 200.
- Random out_ready (50%) over a 540x360 frame vs. a reference model. Expect a bit-exact match, stable outputs during stalls, no drop or duplicate.
- coef_wr of Sobel-x mid-frame. Expect the current frame to stay identity and the next frame (in_sof) to use Sobel. coef_addr=12 leaves both banks unchanged.
- rst asserted mid-row 3. Expect all outputs 0 immediately. The new frame after release matches the model from its first output.
- in_sof asserted at (2,4) of a partial frame. Expect counters to resync; the first output of the new frame appears 3 cycles after its (2,2) pixel.
